// File: rtl/id_ex_stage_pkg.sv
// Shared widths, ALU op codes and the ID/EX pipeline register payload for id_ex_stage.
package id_ex_stage_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_AW = 4;
  localparam int unsigned OP_W   = 4;

  typedef enum logic [OP_W-1:0] {
    ALU_OP_NOP = 4'h0,
    ALU_OP_ADD = 4'h1,
    ALU_OP_SUB = 4'h2,
    ALU_OP_AND = 4'h3,
    ALU_OP_OR  = 4'h4,
    ALU_OP_XOR = 4'h5,
    ALU_OP_SLL = 4'h6,
    ALU_OP_SRL = 4'h7
  } alu_op_e;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs_idx;
    logic              rs_used;
    logic [REG_AW-1:0] rt_idx;
    logic              rt_used;
    logic              a_imm;
    logic              b_imm;
    logic [REG_AW-1:0] dest;
    logic              wb_en;
    logic              mem_rd;
  } id_ex_t;

  // An empty slot: nothing valid, nothing read, nothing written back.
  function automatic id_ex_t id_ex_bubble();
    id_ex_t b;
    b    = '0;
    b.op = ALU_OP_NOP;
    return b;
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// One operand's forwarding select: EX/MEM result over MEM/WB result over the latched value.
module id_ex_stage_fwd_mux #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 4,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic              i_use,
  input  logic [REG_AW-1:0] i_idx,
  input  logic [DATA_W-1:0] i_reg_val,
  input  logic              i_mem_wen,
  input  logic [REG_AW-1:0] i_mem_dest,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic              i_wb_wen,
  input  logic [REG_AW-1:0] i_wb_dest,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic [DATA_W-1:0] o_val
);

  always_comb begin
    o_val = i_reg_val;
    if (FWD_EN && i_use) begin
      if (i_mem_wen && (i_mem_dest == i_idx)) begin
        o_val = i_mem_data;
      end else if (i_wb_wen && (i_wb_dest == i_idx)) begin
        o_val = i_wb_data;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU, with operand forwarding and hazard stalls.
// Build option ID_EX_FWD_EN: forwarding + load-use stall; otherwise stall on any in-flight writer.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [OP_W-1:0]   id_op,
  input  logic [DATA_W-1:0] id_rs_val,
  input  logic [DATA_W-1:0] id_rt_val,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs_idx,
  input  logic              id_rs_used,
  input  logic [REG_AW-1:0] id_rt_idx,
  input  logic              id_rt_used,
  input  logic              id_a_imm,
  input  logic              id_b_imm,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_wb_en,
  input  logic              id_mem_rd,
  input  logic              flush,
  input  logic              mem_wen,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_wen,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic              ex_valid,
  output logic              ex_wb_en,
  output logic              ex_mem_rd,
  output logic [REG_AW-1:0] ex_dest,
  output logic [DATA_W-1:0] ex_rt_fwd,
  output logic              stall_id
);

`ifdef ID_EX_FWD_EN
  localparam bit LP_FWD_EN = 1'b1;
`else
  localparam bit LP_FWD_EN = 1'b0;
`endif

  id_ex_t            r_ex;
  id_ex_t            w_id;
  logic              w_stall;
  logic [DATA_W-1:0] w_rs_fwd;
  logic [DATA_W-1:0] w_rt_fwd;

  // Gather the decoded ID fields into one payload.
  always_comb begin
    w_id         = '0;
    w_id.valid   = id_valid;
    w_id.op      = id_op;
    w_id.rs_val  = id_rs_val;
    w_id.rt_val  = id_rt_val;
    w_id.imm     = id_imm;
    w_id.rs_idx  = id_rs_idx;
    w_id.rs_used = id_rs_used;
    w_id.rt_idx  = id_rt_idx;
    w_id.rt_used = id_rt_used;
    w_id.a_imm   = id_a_imm;
    w_id.b_imm   = id_b_imm;
    w_id.dest    = id_dest;
    w_id.wb_en   = id_wb_en;
    w_id.mem_rd  = id_mem_rd;
  end

`ifdef ID_EX_FWD_EN
  // Only a load in EX cannot be forwarded in time; everything else is bypassed.
  always_comb begin
    w_stall = ~flush & id_valid & r_ex.valid & r_ex.mem_rd & r_ex.wb_en &
              ((id_rs_used & (r_ex.dest == id_rs_idx)) |
               (id_rt_used & (r_ex.dest == id_rt_idx)));
  end
`else
  logic w_rs_hit;
  logic w_rt_hit;

  // Without bypass, wait until no writer of a used source is in EX or EX/MEM.
  always_comb begin
    w_rs_hit = id_rs_used &
               ((r_ex.valid & r_ex.wb_en & (r_ex.dest == id_rs_idx)) |
                (mem_wen & (mem_dest == id_rs_idx)));
    w_rt_hit = id_rt_used &
               ((r_ex.valid & r_ex.wb_en & (r_ex.dest == id_rt_idx)) |
                (mem_wen & (mem_dest == id_rt_idx)));
    w_stall  = ~flush & id_valid & (w_rs_hit | w_rt_hit);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex <= id_ex_bubble();
    end else if (flush || w_stall) begin
      r_ex <= id_ex_bubble();
    end else begin
      r_ex <= w_id;
    end
  end

  id_ex_stage_fwd_mux #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .FWD_EN (LP_FWD_EN)
  ) u_fwd_rs (
    .i_use      (r_ex.rs_used),
    .i_idx      (r_ex.rs_idx),
    .i_reg_val  (r_ex.rs_val),
    .i_mem_wen  (mem_wen),
    .i_mem_dest (mem_dest),
    .i_mem_data (mem_data),
    .i_wb_wen   (wb_wen),
    .i_wb_dest  (wb_dest),
    .i_wb_data  (wb_data),
    .o_val      (w_rs_fwd)
  );

  // The rt path is forwarded even when b takes the immediate, since stores need it.
  id_ex_stage_fwd_mux #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .FWD_EN (LP_FWD_EN)
  ) u_fwd_rt (
    .i_use      (r_ex.rt_used),
    .i_idx      (r_ex.rt_idx),
    .i_reg_val  (r_ex.rt_val),
    .i_mem_wen  (mem_wen),
    .i_mem_dest (mem_dest),
    .i_mem_data (mem_data),
    .i_wb_wen   (wb_wen),
    .i_wb_dest  (wb_dest),
    .i_wb_data  (wb_data),
    .o_val      (w_rt_fwd)
  );

  assign alu_a     = r_ex.a_imm ? r_ex.imm : w_rs_fwd;
  assign alu_b     = r_ex.b_imm ? r_ex.imm : w_rt_fwd;
  assign ex_rt_fwd = w_rt_fwd;
  assign alu_op    = r_ex.op;
  assign ex_valid  = r_ex.valid;
  assign ex_wb_en  = r_ex.wb_en;
  assign ex_mem_rd = r_ex.mem_rd;
  assign ex_dest   = r_ex.dest;
  assign stall_id  = w_stall;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations follow the ID_EX_FWD_EN setting.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [3:0]  id_op;
  logic [15:0] id_rs_val, id_rt_val, id_imm;
  logic [3:0]  id_rs_idx, id_rt_idx, id_dest;
  logic        id_rs_used, id_rt_used, id_a_imm, id_b_imm, id_wb_en, id_mem_rd;
  logic        flush, mem_wen, wb_wen;
  logic [3:0]  mem_dest, wb_dest;
  logic [15:0] mem_data, wb_data;
  logic [15:0] alu_a, alu_b, ex_rt_fwd;
  logic [3:0]  alu_op, ex_dest;
  logic        ex_valid, ex_wb_en, ex_mem_rd, stall_id;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SLL = 4'h6;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm(id_imm),
    .id_rs_idx(id_rs_idx), .id_rs_used(id_rs_used),
    .id_rt_idx(id_rt_idx), .id_rt_used(id_rt_used),
    .id_a_imm(id_a_imm), .id_b_imm(id_b_imm), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_mem_rd(id_mem_rd), .flush(flush),
    .mem_wen(mem_wen), .mem_dest(mem_dest), .mem_data(mem_data),
    .wb_wen(wb_wen), .wb_dest(wb_dest), .wb_data(wb_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .ex_valid(ex_valid), .ex_wb_en(ex_wb_en), .ex_mem_rd(ex_mem_rd),
    .ex_dest(ex_dest), .ex_rt_fwd(ex_rt_fwd), .stall_id(stall_id)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id_clear();
    id_valid = 1'b0; id_op = OP_NOP; id_rs_val = '0; id_rt_val = '0; id_imm = '0;
    id_rs_idx = '0; id_rs_used = 1'b0; id_rt_idx = '0; id_rt_used = 1'b0;
    id_a_imm = 1'b0; id_b_imm = 1'b0; id_dest = '0; id_wb_en = 1'b0; id_mem_rd = 1'b0;
  endtask

  task automatic id_alu(input logic [3:0] op, input logic [3:0] rs, input logic [15:0] rsv,
                        input logic [3:0] rt, input logic [15:0] rtv, input logic [3:0] dst);
    id_clear();
    id_valid = 1'b1; id_op = op; id_rs_idx = rs; id_rs_used = 1'b1; id_rs_val = rsv;
    id_rt_idx = rt; id_rt_used = 1'b1; id_rt_val = rtv; id_dest = dst; id_wb_en = 1'b1;
  endtask

  task automatic id_load(input logic [3:0] dst);
    id_clear();
    id_valid = 1'b1; id_op = OP_ADD; id_dest = dst; id_wb_en = 1'b1; id_mem_rd = 1'b1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; mem_wen = 1'b0; wb_wen = 1'b0;
    mem_dest = '0; wb_dest = '0; mem_data = '0; wb_data = '0;
    id_clear();

    // Reset held for two cycles.
    step(); step();
    chk("rst_alu_op", 32'(alu_op), 32'(OP_NOP));
    chk("rst_valid", 32'(ex_valid), 32'h0);
    chk("rst_stall", 32'(stall_id), 32'h0);
    chk("rst_alu_a", 32'(alu_a), 32'h0);
    chk("rst_alu_b", 32'(alu_b), 32'h0);
    rst = 1'b0;

    // Plain ADD, one cycle ID to ALU.
    id_alu(OP_ADD, 4'd1, 16'h0003, 4'd2, 16'h0004, 4'd7);
    #1 chk("add_stall", 32'(stall_id), 32'h0);
    step(); id_clear(); #1;
    chk("add_alu_a", 32'(alu_a), 32'h0003);
    chk("add_alu_b", 32'(alu_b), 32'h0004);
    chk("add_alu_op", 32'(alu_op), 32'(OP_ADD));
    chk("add_valid", 32'(ex_valid), 32'h1);
    chk("add_dest", 32'(ex_dest), 32'h7);
    chk("add_wb_en", 32'(ex_wb_en), 32'h1);

    // Shift with a = immediate shift amount, b = rt.
    id_clear();
    id_valid = 1'b1; id_op = OP_SLL; id_a_imm = 1'b1; id_imm = 16'h0005;
    id_rt_idx = 4'd2; id_rt_used = 1'b1; id_rt_val = 16'h0010;
    step(); id_clear(); #1;
    chk("sll_alu_a", 32'(alu_a), 32'h0005);
    chk("sll_alu_b", 32'(alu_b), 32'h0010);
    chk("sll_rt_fwd", 32'(ex_rt_fwd), 32'h0010);
    chk("sll_alu_op", 32'(alu_op), 32'(OP_SLL));

    // Load in EX, consumer in ID: stall, then flush overrides it.
    id_load(4'd3);
    step();
    id_alu(OP_ADD, 4'd3, 16'h0000, 4'd1, 16'h0001, 4'd5);
    #1 chk("lu_stall", 32'(stall_id), 32'h1);
    flush = 1'b1;
    #1 chk("flush_stall", 32'(stall_id), 32'h0);
    step(); flush = 1'b0; id_clear(); #1;
    chk("flush_valid", 32'(ex_valid), 32'h0);
    chk("flush_alu_op", 32'(alu_op), 32'(OP_NOP));

    // Reset arriving during a stall empties the pipeline.
    id_load(4'd3);
    step();
    id_alu(OP_ADD, 4'd3, 16'h0000, 4'd1, 16'h0001, 4'd5);
    #1 chk("rs_stall_pre", 32'(stall_id), 32'h1);
    rst = 1'b1;
    step(); rst = 1'b0; #1;
    chk("rs_valid", 32'(ex_valid), 32'h0);
    chk("rs_stall_post", 32'(stall_id), 32'h0);
    step(); id_clear(); #1;
    chk("rs_consumer_in", 32'(ex_valid), 32'h1);

`ifdef ID_EX_FWD_EN
    // EX/MEM beats MEM/WB, MEM/WB beats the latched value.
    id_alu(OP_ADD, 4'd2, 16'h1111, 4'd3, 16'h0022, 4'd4);
    step(); id_clear();
    mem_wen = 1'b1; mem_dest = 4'd2; mem_data = 16'h1234;
    wb_wen = 1'b1; wb_dest = 4'd2; wb_data = 16'h5678;
    #1 chk("fwd_mem", 32'(alu_a), 32'h1234);
    chk("fwd_b_raw", 32'(alu_b), 32'h0022);
    mem_wen = 1'b0;
    #1 chk("fwd_wb", 32'(alu_a), 32'h5678);
    wb_wen = 1'b0;
    #1 chk("fwd_none", 32'(alu_a), 32'h1111);

    // Immediate b is never forwarded; store data still is.
    id_clear();
    id_valid = 1'b1; id_op = OP_ADD; id_b_imm = 1'b1; id_imm = 16'h00FF;
    id_rt_idx = 4'd2; id_rt_used = 1'b1; id_rt_val = 16'h0009;
    step(); id_clear();
    mem_wen = 1'b1; mem_dest = 4'd2; mem_data = 16'hBEEF;
    #1 chk("imm_b_nofwd", 32'(alu_b), 32'h00FF);
    chk("store_fwd", 32'(ex_rt_fwd), 32'hBEEF);
    mem_wen = 1'b0;

    // Load-use: one stall, bubble, then value via MEM/WB.
    id_load(4'd3);
    step();
    id_alu(OP_ADD, 4'd3, 16'h0000, 4'd1, 16'h0001, 4'd5);
    #1 chk("lu_stall1", 32'(stall_id), 32'h1);
    step();
    chk("lu_bubble_valid", 32'(ex_valid), 32'h0);
    chk("lu_bubble_op", 32'(alu_op), 32'(OP_NOP));
    chk("lu_stall_once", 32'(stall_id), 32'h0);
    step(); id_clear();
    wb_wen = 1'b1; wb_dest = 4'd3; wb_data = 16'h00AA;
    #1 chk("lu_alu_a", 32'(alu_a), 32'h00AA);
    chk("lu_alu_b", 32'(alu_b), 32'h0001);
    chk("lu_alu_op", 32'(alu_op), 32'(OP_ADD));
    wb_wen = 1'b0;
`else
    // Back-to-back dependent ADDs: two stall cycles, no forwarding.
    id_alu(OP_ADD, 4'd1, 16'h0004, 4'd2, 16'h0005, 4'd5);
    step();
    id_alu(OP_ADD, 4'd5, 16'h0000, 4'd1, 16'h0004, 4'd6);
    #1 chk("dep_stall1", 32'(stall_id), 32'h1);
    step();
    mem_wen = 1'b1; mem_dest = 4'd5; mem_data = 16'h0009;
    #1 chk("dep_stall2", 32'(stall_id), 32'h1);
    chk("dep_bubble", 32'(ex_valid), 32'h0);
    step();
    mem_wen = 1'b0; wb_wen = 1'b1; wb_dest = 4'd5; wb_data = 16'h0009;
    id_rs_val = 16'h0009;
    #1 chk("dep_stall_clr", 32'(stall_id), 32'h0);
    step(); id_clear();
    wb_data = 16'hFFFF;
    mem_wen = 1'b1; mem_dest = 4'd5; mem_data = 16'hEEEE;
    #1 chk("dep_alu_a_raw", 32'(alu_a), 32'h0009);
    chk("dep_alu_b", 32'(alu_b), 32'h0004);
    chk("dep_alu_op", 32'(alu_op), 32'(OP_ADD));
    mem_wen = 1'b0; wb_wen = 1'b0;

    // Store data is the raw latched rt.
    id_alu(OP_ADD, 4'd1, 16'h0001, 4'd2, 16'h0ABC, 4'd0);
    id_wb_en = 1'b0;
    step(); id_clear();
    mem_wen = 1'b1; mem_dest = 4'd2; mem_data = 16'h5555;
    #1 chk("raw_rt_fwd", 32'(ex_rt_fwd), 32'h0ABC);
    mem_wen = 1'b0;
`endif

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
